wb_arbiter_4_wdt: RTL and testbench

- 4-master to 1-slave Wishbone arbiter with round-robin grant and a bus watchdog.
- Sits between the CPU, DMA and peripheral masters and the shared slave interconnect; replaces chains of 2-port arbiters where fairness and hang recovery are needed.
- The watchdog terminates any slave access that stalls beyond TIMEOUT cycles with an error to the owning master, then frees the bus.

---
 rtl/wb_arbiter_4_wdt.sv | 107 ++++++++++
 tb/tb_wb_arbiter_4_wdt.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_4_wdt.sv
// wb_arbiter_4_wdt: 4-master to 1-slave Wishbone arbiter, round-robin grant, bus watchdog.
//   clk, rst_n            clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o     four master ports, master n at slice n; responses reach the owner only
//   wbs_*_o / wbs_*_i     shared slave port, driven only while a grant is held
//   grant_o               one-hot current owner
//   timeout_o             one-cycle pulse when the watchdog aborts a stalled access
module wb_arbiter_4_wdt #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [4*DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]     wbm_dat_o,
    input  logic [3:0]                wbm_we_i,
    input  logic [4*SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic [3:0]                wbm_stb_i,
    input  logic [3:0]                wbm_cyc_i,
    output logic [3:0]                wbm_ack_o,
    output logic [3:0]                wbm_err_o,
    output logic [3:0]                wbm_rty_o,
    output logic [ADDR_WIDTH-1:0]     wbs_adr_o,
    output logic [DATA_WIDTH-1:0]     wbs_dat_o,
    output logic                      wbs_we_o,
    output logic [SELECT_WIDTH-1:0]   wbs_sel_o,
    output logic                      wbs_stb_o,
    output logic                      wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [3:0]                grant_o,
    output logic                      timeout_o
);
    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_e;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    state_e        state_q;
    logic [3:0]    grant_q;
    logic [1:0]    own_q;
    logic [1:0]    last_q;
    logic [1:0]    pick;
    logic [WW-1:0] wdt_q;
    logic          gnt;
    logic          term;
    logic          stall;
    logic          expire;
    assign gnt    = state_q == GRANT;
    assign term   = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign stall  = gnt && wbs_stb_o && !term;
    // Abort when this stalled cycle is the one that brings the counter to TIMEOUT.
    assign expire = (TIMEOUT != 0) && stall && (wdt_q == WW'(TIMEOUT - 1));
    // Round-robin: scanning downwards leaves the nearest requester after last_q in pick.
    always_comb begin
        pick = last_q;
        for (int k = 4; k >= 1; k--)
            if (wbm_cyc_i[last_q + 2'(k)]) pick = last_q + 2'(k);
    end
    assign wbs_adr_o = gnt ? wbm_adr_i[own_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign wbs_dat_o = gnt ? wbm_dat_i[own_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wbs_sel_o = gnt ? wbm_sel_i[own_q*SELECT_WIDTH +: SELECT_WIDTH] : '0;
    assign wbs_we_o  = gnt && wbm_we_i[own_q];
    assign wbs_stb_o = gnt && wbm_stb_i[own_q];
    assign wbs_cyc_o = gnt;
    assign wbm_dat_o = wbs_dat_i;
    // Slave responses only pass in GRANT, so anything arriving during ABORT is dropped.
    assign wbm_ack_o = (gnt && wbs_ack_i) ? grant_q : 4'b0;
    assign wbm_rty_o = (gnt && wbs_rty_i) ? grant_q : 4'b0;
    assign wbm_err_o = ((gnt && wbs_err_i) || state_q == ABORT) ? grant_q : 4'b0;
    assign grant_o   = grant_q;
    assign timeout_o = state_q == ABORT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            last_q  <= 2'd3;
            wdt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|wbm_cyc_i) begin
                    state_q <= GRANT;
                    own_q   <= pick;
                    grant_q <= 4'b1 << pick;
                end
                GRANT: if (!wbm_cyc_i[own_q]) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    last_q  <= own_q;
                end else if (expire) begin
                    state_q <= ABORT;
                end
                ABORT: if (!wbm_cyc_i[own_q]) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    last_q  <= own_q;
                end else begin
                    state_q <= GRANT;
                end
                default: state_q <= IDLE;
            endcase
            wdt_q <= (stall && TIMEOUT != 0) ? wdt_q + WW'(1) : '0;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_4_wdt.sv
// tb_wb_arbiter_4_wdt: directed bench for the 4-master Wishbone arbiter with watchdog (TIMEOUT=8).
module tb_wb_arbiter_4_wdt;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4*AW-1:0] wbm_adr_i;
    logic [4*DW-1:0] wbm_dat_i;
    logic [DW-1:0]   wbm_dat_o;
    logic [3:0]      wbm_we_i;
    logic [4*SW-1:0] wbm_sel_i;
    logic [3:0]      wbm_stb_i;
    logic [3:0]      wbm_cyc_i;
    logic [3:0]      wbm_ack_o;
    logic [3:0]      wbm_err_o;
    logic [3:0]      wbm_rty_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic            wbs_we_o;
    logic [SW-1:0]   wbs_sel_o;
    logic            wbs_stb_o;
    logic            wbs_cyc_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i;
    logic            wbs_err_i;
    logic            wbs_rty_i;
    logic [3:0]      grant_o;
    logic            timeout_o;
    int vectors = 0;
    int miscompares = 0;

    wb_arbiter_4_wdt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .grant_o(grant_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wbm_cyc_i = 4'b0;
        wbm_stb_i = 4'b0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        #1;
        check("rst_grant", 64'(grant_o), 64'h0);
        check("rst_cyc", 64'(wbs_cyc_o), 64'h0);
        check("rst_adr", 64'(wbs_adr_o), 64'h0);
        check("rst_tmo", 64'(timeout_o), 64'h0);
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < 4; n++) begin
            wbm_adr_i[n*AW +: AW] = 32'hA000_0000 + 32'(n) * 32'h100;
            wbm_dat_i[n*DW +: DW] = 32'hD000_0000 + 32'(n);
            wbm_sel_i[n*SW +: SW] = 4'(n + 1);
        end
        wbm_we_i  = 4'b0101;
        wbs_dat_i = 32'h1234_5678;

        // 1: single master, slave acks after two stalled cycles
        do_reset();
        wbm_cyc_i = 4'b0001;
        wbm_stb_i = 4'b0001;
        #1;
        check("t1_req_cycle_grant", 64'(grant_o), 64'h0);
        nxt();
        #1;
        check("t1_grant", 64'(grant_o), 64'h1);
        check("t1_cyc", 64'(wbs_cyc_o), 64'h1);
        check("t1_adr", 64'(wbs_adr_o), 64'hA000_0000);
        check("t1_dat", 64'(wbs_dat_o), 64'hD000_0000);
        check("t1_we", 64'(wbs_we_o), 64'h1);
        check("t1_sel", 64'(wbs_sel_o), 64'h1);
        check("t1_noack", 64'(wbm_ack_o), 64'h0);
        nxt();
        nxt();
        wbs_ack_i = 1'b1;
        #1;
        check("t1_ack", 64'(wbm_ack_o), 64'h1);
        check("t1_rdat", 64'(wbm_dat_o), 64'h1234_5678);
        nxt();
        wbs_ack_i = 1'b0;
        wbm_cyc_i = 4'b0;
        wbm_stb_i = 4'b0;
        #1;
        check("t1_hold", 64'(grant_o), 64'h1);
        nxt();
        #1;
        check("t1_release", 64'(grant_o), 64'h0);
        check("t1_release_cyc", 64'(wbs_cyc_o), 64'h0);

        // 2: all masters requesting, round robin 0,1,2,3,0
        do_reset();
        wbm_cyc_i = 4'b1111;
        wbm_stb_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            automatic int e = i % 4;
            nxt();
            #1;
            check($sformatf("t2_grant%0d", i), 64'(grant_o), 64'(4'b1 << e));
            check($sformatf("t2_adr%0d", i), 64'(wbs_adr_o), 64'(32'hA000_0000 + 32'(e) * 32'h100));
            wbs_ack_i = 1'b1;
            #1;
            check($sformatf("t2_ack%0d", i), 64'(wbm_ack_o), 64'(4'b1 << e));
            nxt();
            wbs_ack_i = 1'b0;
            wbm_cyc_i = 4'b1111 & ~(4'b1 << e);
            nxt();
            #1;
            check($sformatf("t2_idle%0d", i), 64'(grant_o), 64'h0);
            wbm_cyc_i = 4'b1111;
        end

        // 3: master 2 bursts 4 beats while master 1 waits
        do_reset();
        wbm_cyc_i = 4'b0100;
        wbm_stb_i = 4'b0110;
        nxt();
        wbm_cyc_i = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            wbs_ack_i = 1'b1;
            #1;
            check($sformatf("t3_grant%0d", i), 64'(grant_o), 64'h4);
            check($sformatf("t3_ack%0d", i), 64'(wbm_ack_o), 64'h4);
            nxt();
        end
        wbs_ack_i = 1'b0;
        wbm_cyc_i = 4'b0010;
        nxt();
        #1;
        check("t3_idle", 64'(grant_o), 64'h0);
        nxt();
        #1;
        check("t3_next", 64'(grant_o), 64'h2);
        check("t3_adr", 64'(wbs_adr_o), 64'hA000_0100);

        // 4: master 1 stalls, abort twice (cyc held, then dropped)
        do_reset();
        wbm_cyc_i = 4'b0010;
        wbm_stb_i = 4'b0010;
        nxt();
        for (int i = 1; i <= 8; i++) begin
            #1;
            check($sformatf("t4_stall%0d", i), 64'({timeout_o, wbm_err_o, wbs_cyc_o}), 64'h1);
            nxt();
        end
        wbs_ack_i = 1'b1;
        #1;
        check("t4_tmo", 64'(timeout_o), 64'h1);
        check("t4_err", 64'(wbm_err_o), 64'h2);
        check("t4_cyc0", 64'({wbs_cyc_o, wbs_stb_o}), 64'h0);
        check("t4_discard", 64'(wbm_ack_o), 64'h0);
        nxt();
        wbs_ack_i = 1'b0;
        #1;
        check("t4_regrant", 64'({timeout_o, wbm_err_o, wbs_cyc_o, grant_o}), 64'h12);
        for (int i = 1; i <= 8; i++) begin
            #1;
            check($sformatf("t4_stallb%0d", i), 64'(timeout_o), 64'h0);
            nxt();
        end
        wbm_cyc_i = 4'b0;
        wbm_stb_i = 4'b0;
        #1;
        check("t4_tmo2", 64'(timeout_o), 64'h1);
        nxt();
        #1;
        check("t4_idle", 64'({timeout_o, grant_o}), 64'h0);
        wbm_cyc_i = 4'b1111;
        nxt();
        #1;
        check("t4_last", 64'(grant_o), 64'h4);

        // 5: ack on the 8th stalled cycle wins over the watchdog
        do_reset();
        wbm_cyc_i = 4'b0001;
        wbm_stb_i = 4'b0001;
        nxt();
        for (int i = 1; i <= 7; i++) begin
            #1;
            check($sformatf("t5_stall%0d", i), 64'(timeout_o), 64'h0);
            nxt();
        end
        wbs_ack_i = 1'b1;
        #1;
        check("t5_ack", 64'({wbm_ack_o, wbm_err_o, timeout_o}), 64'h20);
        nxt();
        wbs_ack_i = 1'b0;
        #1;
        check("t5_after", 64'({timeout_o, wbm_err_o, wbs_cyc_o}), 64'h1);
        nxt();
        for (int i = 2; i <= 7; i++) begin
            #1;
            check($sformatf("t5_restall%0d", i), 64'(timeout_o), 64'h0);
            nxt();
        end
        #1;
        check("t5_restall8", 64'({timeout_o, wbs_cyc_o}), 64'h1);
        nxt();
        #1;
        check("t5_abort", 64'(timeout_o), 64'h1);
        wbm_cyc_i = 4'b0;
        wbm_stb_i = 4'b0;
        nxt();

        // 6: asynchronous reset mid-burst
        do_reset();
        wbm_cyc_i = 4'b0100;
        wbm_stb_i = 4'b0100;
        nxt();
        wbs_ack_i = 1'b1;
        #1;
        check("t6_grant", 64'(grant_o), 64'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async", 64'({wbs_cyc_o, grant_o}), 64'h0);
        wbs_ack_i = 1'b0;
        wbm_cyc_i = 4'b1111;
        #1;
        rst_n = 1'b1;
        nxt();
        #1;
        check("t6_first", 64'(grant_o), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
